// File: rtl/udp_tx_packer_if.sv
// Byte-stream input, TX payload RAM write port and frame request/done handshake of udp_tx_packer.
interface udp_tx_packer_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [31:0]       ram_wr_data;
  logic [15:0]       tx_data_length;
  logic [15:0]       tx_total_length;
  logic              tx_req;
  logic              tx_done;
  logic              overflow;

  modport slave (
    input  in_data, in_valid, in_last, tx_done,
    output in_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
           tx_data_length, tx_total_length, tx_req, overflow
  );

  modport master (
    output in_data, in_valid, in_last, tx_done,
    input  in_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
           tx_data_length, tx_total_length, tx_req, overflow
  );
endinterface

// File: rtl/udp_tx_packer.sv
// Packs a byte stream big-endian into 32-bit TX RAM words, computes UDP/IP lengths and
// holds tx_req (blocking input) until the sender pulses tx_done.
module udp_tx_packer #(
  parameter int MAX_BYTES = 1472,
  parameter int ADDR_W    = 9,
  parameter int UDP_HDR   = 8,
  parameter int IP_HDR    = 20
) (
  input  logic           clk,
  input  logic           rst,
  udp_tx_packer_if.slave bus
);
  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);
  localparam logic [15:0] UDP_ADD = 16'(UDP_HDR);
  localparam logic [15:0] TOT_ADD = 16'(UDP_HDR + IP_HDR);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;
  state_t state, state_nxt;

  logic [10:0]       cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       shreg, word_nxt;
  logic              accept, store, wr;

  logic              wr_en_q, ovf_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [15:0]       dlen_q, tlen_q;

  assign accept = bus.in_valid && (state == COLLECT) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.tx_req   = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = !rst;
        if (accept && bus.in_last) state_nxt = HOLD;
      end
      HOLD: begin
        bus.tx_req = 1'b1;
        if (bus.tx_done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    store    = accept && (cnt < MAX_CNT);
    cnt_nxt  = store ? cnt + 11'd1 : cnt;
    word_nxt = shreg;
    if (store) begin
      case (cnt[1:0])
        2'd0: word_nxt[31:24] = bus.in_data;
        2'd1: word_nxt[23:16] = bus.in_data;
        2'd2: word_nxt[15:8]  = bus.in_data;
        2'd3: word_nxt[7:0]   = bus.in_data;
      endcase
    end
    // A last byte flushes any pending partial word, even when that byte itself was dropped.
    wr = (store && cnt[1:0] == 2'd3) ||
         (accept && bus.in_last && (store || cnt[1:0] != 2'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      addr      <= '0;
      shreg     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dlen_q    <= '0;
      tlen_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_en_q <= wr;
      if (wr) begin
        wr_addr_q <= addr;
        wr_data_q <= word_nxt;
        addr      <= addr + ADDR_W'(1);
        shreg     <= '0;
      end else begin
        shreg <= word_nxt;
      end
      cnt <= cnt_nxt;
      if (accept && !store) ovf_q <= 1'b1;
      if (accept && bus.in_last) begin
        dlen_q <= {5'd0, cnt_nxt} + UDP_ADD;
        tlen_q <= {5'd0, cnt_nxt} + TOT_ADD;
      end
      if (state == HOLD && bus.tx_done) begin
        cnt   <= '0;
        addr  <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.ram_wr_en       = wr_en_q;
  assign bus.ram_wr_addr     = wr_addr_q;
  assign bus.ram_wr_data     = wr_data_q;
  assign bus.tx_data_length  = dlen_q;
  assign bus.tx_total_length = tlen_q;
  assign bus.overflow        = ovf_q;
endmodule

// File: tb/tb_udp_tx_packer.sv
// Randomized frames against a byte-list model of udp_tx_packer, plus hand-computed frame checks.
module tb_udp_tx_packer;
  localparam int MAXB   = 8;
  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udp_tx_packer_if #(.ADDR_W(ADDR_W)) bus ();

  udp_tx_packer #(.MAX_BYTES(MAXB), .ADDR_W(ADDR_W), .UDP_HDR(8), .IP_HDR(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  // Model state: bytes stored this frame, pending partial word, expected RAM writes.
  logic [7:0]  m_buf[$];
  wr_t         exp_q[$];
  int          m_cnt = 0;
  int          m_addr = 0;
  bit          m_hold = 0;
  bit          m_ovf = 0;
  logic [15:0] m_dlen = '0;
  logic [15:0] m_tlen = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < m_buf.size(); i++) w[31-8*i -: 8] = m_buf[i];
    exp_q.push_back('{addr: m_addr, data: w});
    m_addr++;
    m_buf.delete();
  endfunction

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.tx_done  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.tx_done  = 1'b0;
    if (!m_hold) begin
      if (m_cnt < MAXB) begin
        m_buf.push_back(d);
        m_cnt++;
        if (m_buf.size() == 4) push_word();
      end else begin
        m_ovf = 1;
      end
      if (l) begin
        if (m_buf.size() > 0) push_word();
        m_dlen = 16'(m_cnt + 8);
        m_tlen = 16'(m_cnt + 28);
        m_hold = 1;
      end
    end
  endtask

  // Returns at the negedge following acceptance of the last byte.
  task automatic send_frame(input logic [7:0] b[$], input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        drive_idle();
      end
      send_byte(b[i], i == b.size() - 1);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic pulse_done();
    @(negedge clk);
    drive_idle();
    bus.tx_done = 1'b1;
    if (m_hold) begin
      m_hold = 0;
      m_ovf  = 0;
      m_cnt  = 0;
      m_addr = 0;
      m_buf.delete();
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_wr_en"}, bus.ram_wr_en, 0);
    chk({tag, "_wr_addr"}, bus.ram_wr_addr, 0);
    chk({tag, "_wr_data"}, bus.ram_wr_data, 0);
    chk({tag, "_dlen"}, bus.tx_data_length, 0);
    chk({tag, "_tlen"}, bus.tx_total_length, 0);
    chk({tag, "_tx_req"}, bus.tx_req, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
  endtask

  task automatic chk_frame(input string tag, input bit wr, input int addr, input logic [31:0] data,
                           input int dlen, input int tlen);
    chk({tag, "_tx_req"}, bus.tx_req, 1);
    chk({tag, "_wr_en"}, bus.ram_wr_en, 32'(wr));
    if (wr) begin
      chk({tag, "_wr_addr"}, bus.ram_wr_addr, addr);
      chk({tag, "_wr_data"}, bus.ram_wr_data, data);
    end
    chk({tag, "_dlen"}, bus.tx_data_length, dlen);
    chk({tag, "_tlen"}, bus.tx_total_length, tlen);
  endtask

  // Cycle-by-cycle comparison against the model, sampled just after each rising edge.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("in_ready", bus.in_ready, !m_hold);
        chk("tx_req", bus.tx_req, m_hold);
        chk("overflow", bus.overflow, m_ovf);
        chk("tx_data_length", bus.tx_data_length, m_dlen);
        chk("tx_total_length", bus.tx_total_length, m_tlen);
        if (bus.ram_wr_en) begin
          n_writes++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.ram_wr_addr,
                     bus.ram_wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("ram_wr_addr", bus.ram_wr_addr, e.addr);
            chk("ram_wr_data", bus.ram_wr_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    int w0;

    drive_idle();
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    chk_zero("reset_hold");
    rst = 1'b0;

    // Single full word.
    q.delete();
    q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC); q.push_back(8'hDD);
    w0 = n_writes;
    send_frame(q, 0);
    chk_frame("t1", 1, 0, 32'hAABBCCDD, 12, 32);
    chk("t1_writes", n_writes - w0, 1);
    pulse_done();

    // Full word plus one-byte partial word.
    q.delete();
    for (int i = 1; i <= 5; i++) q.push_back(8'(i));
    w0 = n_writes;
    send_frame(q, 0);
    chk_frame("t2", 1, 1, 32'h05000000, 13, 33);
    chk("t2_writes", n_writes - w0, 2);

    // Back-pressure while holding.
    w0 = n_writes;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'($urandom));
    @(negedge clk);
    drive_idle();
    chk("t3_in_ready", bus.in_ready, 0);
    chk("t3_writes", n_writes - w0, 0);
    chk("t3_dlen", bus.tx_data_length, 13);
    chk("t3_tlen", bus.tx_total_length, 33);
    pulse_done();
    chk("t3_req_drop", bus.tx_req, 0);

    // Overflow: 11 bytes into an 8-byte frame.
    q.delete();
    for (int i = 0; i < 11; i++) q.push_back(8'(8'h10 + i));
    w0 = n_writes;
    send_frame(q, 0);
    chk_frame("t4", 0, 0, 32'h0, 16, 36);
    chk("t4_overflow", bus.overflow, 1);
    chk("t4_writes", n_writes - w0, 2);
    pulse_done();
    chk("t4_overflow_clear", bus.overflow, 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) send_byte(8'(8'h60 + i), 0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    m_hold = 0; m_ovf = 0; m_cnt = 0; m_addr = 0; m_dlen = '0; m_tlen = '0;
    m_buf.delete();
    exp_q.delete();
    #1;
    chk_zero("t5_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    send_frame(q, 0);
    chk_frame("t5", 1, 0, 32'h11223344, 12, 32);
    pulse_done();

    // Stray tx_done in COLLECT, then a single-byte frame.
    pulse_done();
    chk("t6_stray_done_ready", bus.in_ready, 1);
    q.delete();
    q.push_back(8'h7E);
    send_frame(q, 0);
    chk_frame("t6", 1, 0, 32'h7E000000, 9, 29);
    pulse_done();

    // Randomized frames with gaps and variable hold time.
    for (int f = 0; f < 60; f++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 13); i++) q.push_back(8'($urandom));
      send_frame(q, 1);
      for (int i = 0; i < $urandom_range(0, 4); i++) send_byte(8'($urandom), 1'($urandom));
      pulse_done();
      if ($urandom_range(0, 2) == 0) pulse_done();
    end

    repeat (2) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
